// File: rtl/fft_pkg.sv
// Shared FFT constants and helpers: default frame geometry, clog2 and bit reversal.
package fft_pkg;

  localparam int unsigned FftN     = 1024;
  localparam int unsigned FftWidth = 8;

  typedef enum logic {StIdle, StRead} rd_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Reverses the low `bits` bits of value; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned bits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) r[i] = value[bits - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a resettable output register.
module fft_reorder_ram #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Width = 16,
  parameter int unsigned Aw    = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Aw-1:0]    wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [Aw-1:0]    rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Output register holds its value between reads and clears on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT output frames and streams them in natural order.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N     = FftN,
  parameter int unsigned WIDTH = FftWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_in,
  input  logic [WIDTH-1:0]      in_re,
  input  logic [WIDTH-1:0]      in_im,
  output logic                  enable_out,
  output logic [WIDTH-1:0]      out_re,
  output logic [WIDTH-1:0]      out_im,
  output logic [clog2(N)-1:0]   out_index,
  output logic                  out_last
);

  localparam int unsigned Aw = clog2(N);
  localparam logic [Aw-1:0] LastIdx = Aw'(N - 1);

  logic [Aw-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    full_q, full_d;
  logic          wr_wrap;

  logic [Aw-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic          other_bank;
  rd_state_e     state_q, state_d;
  logic          rd_en, rd_done;

  logic          enable_out_q, out_last_q;
  logic [Aw-1:0] out_index_q;
  logic [2*WIDTH-1:0] rd_data;
  logic [Aw:0]   wr_addr, rd_addr;

  // Write side
  assign wr_wrap = enable_in && (wr_cnt_q == LastIdx);
  assign wr_addr = {wr_bank_q, Aw'(bitrev(32'(wr_cnt_q), Aw))};

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    if (enable_in) wr_cnt_d = wr_cnt_q + 1'b1;
    if (wr_wrap) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    // The writer never owns rd_bank while it is being drained, so this cannot undo a set.
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  // Reader FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
    end
  end

  // Reader FSM: next state
  assign other_bank = ~rd_bank_q;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d  = StRead;
          rd_cnt_d = '0;
        end
      end
      StRead: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_done) begin
          rd_bank_d = other_bank;
          // Chain straight into the next bank if it is full, or fills on this very edge.
          if (!(full_q[other_bank] || (wr_wrap && (wr_bank_q == other_bank)))) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reader FSM: outputs
  always_comb begin
    rd_en   = (state_q == StRead);
    rd_done = rd_en && (rd_cnt_q == LastIdx);
  end

  assign rd_addr = {rd_bank_q, rd_cnt_q};

  fft_reorder_ram #(
    .Depth (2 * N),
    .Width (2 * WIDTH),
    .Aw    (Aw + 1)
  ) u_ram (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (enable_in),
    .wr_addr_i (wr_addr),
    .wr_data_i ({in_re, in_im}),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Sideband registers aligned with the synchronous RAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_out_q <= 1'b0;
      out_last_q   <= 1'b0;
      out_index_q  <= '0;
    end else begin
      enable_out_q <= rd_en;
      out_last_q   <= rd_done;
      if (rd_en) out_index_q <= rd_cnt_q;
    end
  end

  assign enable_out = enable_out_q;
  assign out_last   = out_last_q;
  assign out_index  = out_index_q;
  assign out_re     = rd_data[2*WIDTH-1:WIDTH];
  assign out_im     = rd_data[WIDTH-1:0];

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder at N=16, WIDTH=8.
module tb_fft_out_reorder;

  localparam int unsigned N     = 16;
  localparam int unsigned WIDTH = 8;
  localparam int          Steps = 64;

  logic             clk;
  logic             rst_n;
  logic             enable_in;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             enable_out;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic [3:0]       out_index;
  logic             out_last;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Natural bin j holds input sample bitrev4(j)
  int rev_tbl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic exp_v    [Steps];
  int   exp_re   [Steps];
  int   exp_im   [Steps];
  int   exp_idx  [Steps];
  logic exp_last [Steps];

  fft_out_reorder #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_in  (enable_in),
    .in_re      (in_re),
    .in_im      (in_im),
    .enable_out (enable_out),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_index  (out_index),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds nframes frames (optionally every other cycle) and checks every cycle's outputs.
  // Stops right after the checks of step abort_at when abort_at >= 0.
  task automatic run_frames(input string name, input int nframes, input bit gapped,
                            input int abort_at);
    int k;
    int total;
    int base;
    k     = 0;
    total = nframes * 16;
    for (int i = 0; i < Steps; i++) exp_v[i] = 1'b0;
    for (int s = 0; s < Steps; s++) begin
      if (exp_v[s]) begin
        chk({name, ":en"},   32'(enable_out), 32'd1);
        chk({name, ":re"},   32'(out_re),     32'(exp_re[s]));
        chk({name, ":im"},   32'(out_im),     32'(exp_im[s]));
        chk({name, ":idx"},  32'(out_index),  32'(exp_idx[s]));
        chk({name, ":last"}, 32'(out_last),   32'(exp_last[s]));
      end else begin
        chk({name, ":en_idle"},   32'(enable_out), 32'd0);
        chk({name, ":last_idle"}, 32'(out_last),   32'd0);
      end
      if (s == abort_at) return;
      if (k < total && (!gapped || (s % 2 == 0))) begin
        enable_in = 1'b1;
        in_re     = WIDTH'(k);
        in_im     = WIDTH'(8'hF0 + (k % 16));
        // Sample driven at step s is taken at edge s+1; bin 0 shows after edge s+3.
        if (k % 16 == 15) begin
          base = (k / 16) * 16;
          for (int j = 0; j < 16; j++) begin
            exp_v[s + 3 + j]    = 1'b1;
            exp_re[s + 3 + j]   = base + rev_tbl[j];
            exp_im[s + 3 + j]   = 8'hF0 + rev_tbl[j];
            exp_idx[s + 3 + j]  = j;
            exp_last[s + 3 + j] = (j == 15);
          end
        end
        k++;
      end else begin
        enable_in = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    enable_in = 1'b0;
    in_re     = '0;
    in_im     = '0;
    #12;
    chk("reset:en",   32'(enable_out), 32'd0);
    chk("reset:re",   32'(out_re),     32'd0);
    chk("reset:im",   32'(out_im),     32'd0);
    chk("reset:idx",  32'(out_index),  32'd0);
    chk("reset:last", 32'(out_last),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_frames("single", 1, 1'b0, -1);
    // Outputs hold the final sample while idle
    chk("hold:re",  32'(out_re),    32'd15);
    chk("hold:im",  32'(out_im),    32'hFF);
    chk("hold:idx", 32'(out_index), 32'd15);

    run_frames("b2b", 2, 1'b0, -1);
    run_frames("gapped", 1, 1'b1, -1);

    // Reset right after the 5th output sample (bin 4 at step 22)
    run_frames("mid_burst", 1, 1'b0, 22);
    enable_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_burst:en",   32'(enable_out), 32'd0);
    chk("rst_burst:re",   32'(out_re),     32'd0);
    chk("rst_burst:im",   32'(out_im),     32'd0);
    chk("rst_burst:idx",  32'(out_index),  32'd0);
    chk("rst_burst:last", 32'(out_last),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    run_frames("after_burst_rst", 1, 1'b0, -1);

    // Reset after 7 input samples; the partial frame must be discarded
    run_frames("mid_frame", 1, 1'b0, 7);
    enable_in = 1'b0;
    #2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_frames("after_frame_rst", 1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
